// File: rtl/iiitb_lifo_master.sv
// Initiator for the iiitb_lifo stack: turns push/pop/drain commands into EN/RW cycles guarded by FULL/EMPTY.
// Optional drain command (op 10) is built only when LIFO_MASTER_DRAIN_EN is defined; otherwise it is refused.
module iiitb_lifo_master #(
   parameter int DW    = 4,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          Rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          rsp_last,
   output logic          lifo_en_o,
   output logic          lifo_rw_o,
   output logic [DW-1:0] lifo_data_o,
   input  logic [DW-1:0] lifo_data_i,
   input  logic          lifo_empty_i,
   input  logic          lifo_full_i,
   output logic [2:0]    depth_o
);

   typedef enum logic [2:0] {RESET, INIT, IDLE, PUSH, POP, CAP, RSP} state_t;

   state_t        state;
   state_t        state_next;
   logic [DW-1:0] data_q;
   logic          accept;
   logic          cmd_err;
   logic          drain_q;

   assign accept = cmd_valid && cmd_ready;

`ifdef LIFO_MASTER_DRAIN_EN
   // Remembers whether the command in flight is a drain, so RSP knows to loop back to POP.
   always_ff @(posedge clk) begin
      if (Rst) begin
         drain_q <= 1'b0;
      end else if (accept) begin
         drain_q <= (cmd_op == 2'b10);
      end
   end
`else
   assign drain_q = 1'b0;
`endif

   always_comb begin
      state_next  = state;
      lifo_en_o   = 1'b0;
      lifo_rw_o   = 1'b1;
      lifo_data_o = '0;
      cmd_err     = 1'b0;
      case (state)
         RESET: begin
            lifo_en_o  = 1'b1;
            state_next = INIT;
         end
         INIT: begin
            // Pop on an empty stack is harmless and gives FULL a defined value.
            lifo_en_o  = 1'b1;
            state_next = IDLE;
         end
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  2'b00: begin
                     cmd_err    = lifo_full_i;
                     state_next = lifo_full_i ? RSP : PUSH;
                  end
                  2'b01: begin
                     cmd_err    = lifo_empty_i;
                     state_next = lifo_empty_i ? RSP : POP;
                  end
`ifdef LIFO_MASTER_DRAIN_EN
                  2'b10: begin
                     cmd_err    = lifo_empty_i;
                     state_next = lifo_empty_i ? RSP : POP;
                  end
`endif
                  default: begin
                     cmd_err    = 1'b1;
                     state_next = RSP;
                  end
               endcase
            end
         end
         PUSH: begin
            lifo_en_o   = 1'b1;
            lifo_rw_o   = 1'b0;
            lifo_data_o = data_q;
            state_next  = RSP;
         end
         POP: begin
            lifo_en_o  = 1'b1;
            state_next = CAP;
         end
         CAP: begin
            state_next = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               state_next = (drain_q && !rsp_last) ? POP : IDLE;
            end
         end
         default: begin
            state_next = RESET;
         end
      endcase
      // Reset must clear the stack on the very edge it is sampled, whatever state we are in.
      if (Rst) begin
         lifo_en_o   = 1'b1;
         lifo_rw_o   = 1'b1;
         lifo_data_o = '0;
      end
   end

   // State register plus all registered outputs; response fields only change on the way into RSP.
   always_ff @(posedge clk) begin
      if (Rst) begin
         state     <= RESET;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         rsp_last  <= 1'b0;
         depth_o   <= 3'd0;
         data_q    <= '0;
      end else begin
         state     <= state_next;
         cmd_ready <= (state_next == IDLE);
         rsp_valid <= (state_next == RSP);
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q   <= cmd_data;
                  rsp_data <= '0;
                  rsp_err  <= cmd_err;
                  rsp_last <= 1'b1;
               end
            end
            PUSH: begin
               if (depth_o != 3'(DEPTH)) begin
                  depth_o <= depth_o + 3'd1;
               end
               rsp_data <= '0;
               rsp_err  <= 1'b0;
               rsp_last <= 1'b1;
            end
            POP: begin
               if (depth_o != 3'd0) begin
                  depth_o <= depth_o - 3'd1;
               end
            end
            CAP: begin
               rsp_data <= lifo_data_i;
               rsp_err  <= 1'b0;
               rsp_last <= drain_q ? lifo_empty_i : 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iiitb_lifo_master.sv
// Self-checking bench for iiitb_lifo_master with a behavioural 4x4 stack attached.
// Drain expectations follow LIFO_MASTER_DRAIN_EN exactly as the design is built.
module tb_iiitb_lifo_master;

   localparam int DW    = 4;
   localparam int DEPTH = 4;

   logic          clk;
   logic          Rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          rsp_last;
   logic          lifo_en_o;
   logic          lifo_rw_o;
   logic [DW-1:0] lifo_data_o;
   logic [DW-1:0] lifo_data_i;
   logic          lifo_empty_i;
   logic          lifo_full_i;
   logic [2:0]    depth_o;

   int n_checks = 0;
   int n_fail   = 0;
   int en_count = 0;
   int bad_ops  = 0;

   iiitb_lifo_master #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .Rst(Rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_last(rsp_last),
      .lifo_en_o(lifo_en_o), .lifo_rw_o(lifo_rw_o), .lifo_data_o(lifo_data_o),
      .lifo_data_i(lifo_data_i), .lifo_empty_i(lifo_empty_i), .lifo_full_i(lifo_full_i),
      .depth_o(depth_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stack: FULL stays unknown until the first non-reset enabled cycle.
   logic [DW-1:0] stk_mem [DEPTH];
   int            stk_cnt = 0;
   logic          stk_full;
   logic          stk_empty;
   logic [DW-1:0] stk_dout;

   assign lifo_data_i  = stk_dout;
   assign lifo_empty_i = stk_empty;
   assign lifo_full_i  = stk_full;

   always @(posedge clk) begin
      if (lifo_en_o) begin
         if (Rst) begin
            stk_cnt   <= 0;
            stk_empty <= 1'b1;
            stk_dout  <= '0;
         end else begin
            en_count++;
            if (lifo_rw_o) begin
               if (stk_cnt > 0) begin
                  stk_dout <= stk_mem[stk_cnt-1];
                  stk_cnt  <= stk_cnt - 1;
               end
               stk_empty <= (stk_cnt <= 1);
               stk_full  <= 1'b0;
            end else begin
               if (stk_cnt < DEPTH) begin
                  stk_mem[stk_cnt] <= lifo_data_o;
                  stk_cnt          <= stk_cnt + 1;
               end else begin
                  bad_ops++;
               end
               stk_empty <= 1'b0;
               stk_full  <= (stk_cnt >= DEPTH - 1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [1:0]    op;
      logic [DW-1:0] data;
      logic [DW-1:0] exp_data;
      logic          exp_err;
      logic          exp_last;
      int            exp_lat;
      int            exp_depth;
      int            exp_en;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
      logic          l;
   } rsp_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      Rst = 1'b1;
      repeat (3) tick();
      Rst = 1'b0;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] data, output bit ok);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      while (!cmd_ready && n < 40) begin
         tick();
         n++;
      end
      ok = cmd_ready;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Latency is the first edge that samples rsp_valid high, counted from the handshake edge.
   task automatic get_rsp(input int hold, output rsp_t r, output int lat, output bit ok);
      int j = 0;
      rsp_ready = 1'b0;
      while (!rsp_valid && j < 40) begin
         tick();
         j++;
      end
      ok   = rsp_valid;
      lat  = j + 1;
      r.d  = rsp_data;
      r.e  = rsp_err;
      r.l  = rsp_last;
      repeat (hold) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [DW-1:0] data,
                                output rsp_t r, output int lat);
      bit ok_c;
      bit ok_r;
      send_cmd(op, data, ok_c);
      check({tag, "_cmd_ready"}, 32'(ok_c), 32'd1);
      get_rsp(0, r, lat, ok_r);
      check({tag, "_rsp_valid"}, 32'(ok_r), 32'd1);
   endtask

   task automatic checkOutput(input string tag, input rsp_t r, input logic [DW-1:0] d,
                              input logic e, input logic l);
      check({tag, "_data"}, 32'(r.d), 32'(d));
      check({tag, "_err"},  32'(r.e), 32'(e));
      check({tag, "_last"}, 32'(r.l), 32'(l));
   endtask

   vec_t vecs [13];
   int   model [$];
   rsp_t exp_q [$];

   initial begin
      rsp_t r;
      int   lat;
      int   en0;
      bit   ok;

      Rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = '0;
      rsp_ready = 1'b0;

      vecs[0]  = '{2'b00, 4'hA, 4'h0, 1'b0, 1'b1, 2, 1, 1};
      vecs[1]  = '{2'b01, 4'h0, 4'hA, 1'b0, 1'b1, 3, 0, 1};
      vecs[2]  = '{2'b00, 4'h1, 4'h0, 1'b0, 1'b1, 2, 1, 1};
      vecs[3]  = '{2'b00, 4'h2, 4'h0, 1'b0, 1'b1, 2, 2, 1};
      vecs[4]  = '{2'b00, 4'h3, 4'h0, 1'b0, 1'b1, 2, 3, 1};
      vecs[5]  = '{2'b00, 4'h4, 4'h0, 1'b0, 1'b1, 2, 4, 1};
      vecs[6]  = '{2'b00, 4'h5, 4'h0, 1'b1, 1'b1, 1, 4, 0};
      vecs[7]  = '{2'b01, 4'h0, 4'h4, 1'b0, 1'b1, 3, 3, 1};
      vecs[8]  = '{2'b01, 4'h0, 4'h3, 1'b0, 1'b1, 3, 2, 1};
      vecs[9]  = '{2'b01, 4'h0, 4'h2, 1'b0, 1'b1, 3, 1, 1};
      vecs[10] = '{2'b01, 4'h0, 4'h1, 1'b0, 1'b1, 3, 0, 1};
      vecs[11] = '{2'b01, 4'h0, 4'h0, 1'b1, 1'b1, 1, 0, 0};
      vecs[12] = '{2'b11, 4'hF, 4'h0, 1'b1, 1'b1, 1, 0, 0};

      // Reset state, INIT cycle and the FULL flag becoming defined.
      tick();
      tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_depth", 32'(depth_o), 32'd0);
      check("rst_en", 32'(lifo_en_o), 32'd1);
      check("rst_rw", 32'(lifo_rw_o), 32'd1);
      Rst = 1'b0;
      tick();
      check("init_cmd_ready", 32'(cmd_ready), 32'd0);
      check("init_en", 32'(lifo_en_o), 32'd1);
      tick();
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      check("idle_full_defined", 32'(lifo_full_i), 32'd0);
      check("idle_empty", 32'(lifo_empty_i), 32'd1);
      check("idle_en", 32'(lifo_en_o), 32'd0);

      // Table vectors: push/pop, fill to full, overflow, LIFO order, underflow, reserved op.
      for (int i = 0; i < 13; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         en0 = en_count;
         applyStimulus(tag, vecs[i].op, vecs[i].data, r, lat);
         checkOutput(tag, r, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_last);
         check({tag, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
         check({tag, "_depth"}, 32'(depth_o), 32'(vecs[i].exp_depth));
         check({tag, "_en_pulses"}, 32'(en_count - en0), 32'(vecs[i].exp_en));
      end

      // Drain sequence.
      applyStimulus("drn_push7", 2'b00, 4'h7, r, lat);
      applyStimulus("drn_push9", 2'b00, 4'h9, r, lat);
      en0 = en_count;
      applyStimulus("drn_a", 2'b10, 4'h0, r, lat);
`ifdef LIFO_MASTER_DRAIN_EN
      checkOutput("drn_a", r, 4'h9, 1'b0, 1'b0);
      check("drn_a_lat", 32'(lat), 32'd3);
      get_rsp(0, r, lat, ok);
      check("drn_b_rsp_valid", 32'(ok), 32'd1);
      checkOutput("drn_b", r, 4'h7, 1'b0, 1'b1);
      check("drn_b_lat", 32'(lat), 32'd3);
      check("drn_depth", 32'(depth_o), 32'd0);
      check("drn_en_pulses", 32'(en_count - en0), 32'd2);
      applyStimulus("drn_again", 2'b10, 4'h0, r, lat);
      checkOutput("drn_again", r, 4'h0, 1'b1, 1'b1);
`else
      checkOutput("drn_off", r, 4'h0, 1'b1, 1'b1);
      check("drn_off_lat", 32'(lat), 32'd1);
      check("drn_off_depth", 32'(depth_o), 32'd2);
      check("drn_off_en_pulses", 32'(en_count - en0), 32'd0);
`endif

      // Stalled pop response, then reset mid-response.
      apply_reset();
      applyStimulus("stl_push", 2'b00, 4'h3, r, lat);
      send_cmd(2'b01, 4'h0, ok);
      check("stl_cmd_ready", 32'(ok), 32'd1);
      begin
         int j = 0;
         while (!rsp_valid && j < 40) begin
            tick();
            j++;
         end
      end
      check("stl_valid", 32'(rsp_valid), 32'd1);
      en0 = en_count;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("stl%0d_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("stl%0d_data", k), 32'(rsp_data), 32'h3);
         check($sformatf("stl%0d_en", k), 32'(lifo_en_o), 32'd0);
      end
      check("stl_en_pulses", 32'(en_count - en0), 32'd0);
      Rst = 1'b1;
      tick();
      check("stl_rst_valid", 32'(rsp_valid), 32'd0);
      check("stl_rst_depth", 32'(depth_o), 32'd0);
      check("stl_rst_empty", 32'(lifo_empty_i), 32'd1);
      tick();
      Rst = 1'b0;
      applyStimulus("stl_pop_after", 2'b01, 4'h0, r, lat);
      checkOutput("stl_pop_after", r, 4'h0, 1'b1, 1'b1);

      // Randomised commands against a queue model of the stack.
      apply_reset();
      model.delete();
      for (int n = 0; n < 250; n++) begin
         int          sel;
         logic [1:0]  op;
         logic [DW-1:0] d;
         rsp_t        er;
         sel = $urandom_range(0, 9);
         op  = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
         d   = DW'($urandom_range(0, 15));
         exp_q.delete();
         if (op == 2'b00) begin
            if (model.size() == DEPTH) begin
               er = '{4'h0, 1'b1, 1'b1};
            end else begin
               model.push_back(int'(d));
               er = '{4'h0, 1'b0, 1'b1};
            end
            exp_q.push_back(er);
         end else if (op == 2'b01) begin
            if (model.size() == 0) begin
               er = '{4'h0, 1'b1, 1'b1};
            end else begin
               er = '{DW'(model.pop_back()), 1'b0, 1'b1};
            end
            exp_q.push_back(er);
         end else if (op == 2'b10) begin
`ifdef LIFO_MASTER_DRAIN_EN
            if (model.size() == 0) begin
               er = '{4'h0, 1'b1, 1'b1};
               exp_q.push_back(er);
            end else begin
               while (model.size() > 0) begin
                  er.d = DW'(model.pop_back());
                  er.e = 1'b0;
                  er.l = (model.size() == 0);
                  exp_q.push_back(er);
               end
            end
`else
            er = '{4'h0, 1'b1, 1'b1};
            exp_q.push_back(er);
`endif
         end else begin
            er = '{4'h0, 1'b1, 1'b1};
            exp_q.push_back(er);
         end

         send_cmd(op, d, ok);
         if (!ok) begin
            check($sformatf("rnd%0d_cmd_ready", n), 32'(ok), 32'd1);
         end
         foreach (exp_q[k]) begin
            get_rsp($urandom_range(0, 2), r, lat, ok);
            if (!ok) begin
               check($sformatf("rnd%0d_%0d_rsp_valid", n, k), 32'(ok), 32'd1);
            end
            checkOutput($sformatf("rnd%0d_%0d", n, k), r, exp_q[k].d, exp_q[k].e, exp_q[k].l);
         end
         check($sformatf("rnd%0d_depth", n), 32'(depth_o), 32'(model.size()));
      end

      check("stack_overflow_ops", 32'(bad_ops), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
